// File: rtl/register_file_pkg.sv
// register_file_pkg -- shared types for the register file and its clear sequencer.
// Rev 1.0
`default_nettype none

package register_file_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

endpackage

`default_nettype wire

// File: rtl/register_file_clear_seq.sv
// register_file_clear_seq -- soft-clear FSM sweeping one entry per cycle.
// Rev 1.0
`default_nettype none

module register_file_clear_seq
  import register_file_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req,
  output logic          busy,
  output logic          clr_done,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  clr_state_t    r_state;
  clr_state_t    w_state_next;
  logic [AW-1:0] r_ptr;
  logic [AW-1:0] w_ptr_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
    end
  end

  // Pointer wraps to 0 at LAST_ADDR so it never leaves the valid range.
  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    case (r_state)
      ST_IDLE: begin
        if (clr_req) begin
          w_state_next = ST_CLEAR;
          w_ptr_next   = '0;
        end
      end
      ST_CLEAR: begin
        if (r_ptr == LAST_ADDR) begin
          w_state_next = ST_IDLE;
          w_ptr_next   = '0;
        end else begin
          w_ptr_next = r_ptr + AW'(1);
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_ptr_next   = '0;
      end
    endcase
  end

  assign busy     = (r_state == ST_CLEAR);
  assign clr_done = busy && (r_ptr == LAST_ADDR);
  assign clr_we   = busy;
  assign clr_addr = r_ptr;

endmodule

`default_nettype wire

// File: rtl/register_file.sv
// register_file -- DEPTH x WIDTH storage, 1 write / 2 registered read ports, bypass, soft clear.
// Rev 1.0
`default_nettype none

module register_file
  import register_file_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_a,
  output logic [WIDTH-1:0]         rd_data_a,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_b,
  output logic [WIDTH-1:0]         rd_data_b,
  input  logic                     clr_req,
  output logic                     busy,
  output logic                     clr_done,
  output logic                     wr_err
);

  localparam int            AW        = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_EXT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_clr_we;
  logic [AW-1:0]    w_clr_addr;
  logic             w_wr_valid;
  logic [WIDTH-1:0] w_rd_next_a;
  logic [WIDTH-1:0] w_rd_next_b;

  function automatic logic addr_ok(input logic [AW-1:0] addr);
    return ({1'b0, addr} < DEPTH_EXT);
  endfunction

  register_file_clear_seq #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clear_seq (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_done (clr_done),
    .clr_we   (w_clr_we),
    .clr_addr (w_clr_addr)
  );

  // Writes are dropped for the whole sweep, so clr_we and w_wr_valid never coincide.
  assign w_wr_valid = wr_en && !busy && addr_ok(wr_addr);

  always_comb begin
    w_rd_next_a = r_mem[rd_addr_a];
    if (busy || !addr_ok(rd_addr_a)) begin
      w_rd_next_a = '0;
    end else if (w_wr_valid && (wr_addr == rd_addr_a)) begin
      w_rd_next_a = wr_data;
    end
  end

  always_comb begin
    w_rd_next_b = r_mem[rd_addr_b];
    if (busy || !addr_ok(rd_addr_b)) begin
      w_rd_next_b = '0;
    end else if (w_wr_valid && (wr_addr == rd_addr_b)) begin
      w_rd_next_b = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_clr_we) begin
      r_mem[w_clr_addr] <= '0;
    end else if (w_wr_valid) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_a <= '0;
      rd_data_b <= '0;
      wr_err    <= 1'b0;
    end else begin
      rd_data_a <= w_rd_next_a;
      rd_data_b <= w_rd_next_b;
      wr_err    <= wr_en && !w_wr_valid;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_register_file.sv
// tb_register_file -- directed checks of register_file at DEPTH=8 and DEPTH=5.
// Rev 1.0
`default_nettype none

module tb_register_file;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // DEPTH=8 instance
  logic       wr_en = 1'b0, clr_req = 1'b0;
  logic [2:0] wr_addr = '0, rd_addr_a = '0, rd_addr_b = '0;
  logic [7:0] wr_data = '0, rd_data_a, rd_data_b;
  logic       busy, clr_done, wr_err;

  // DEPTH=5 instance
  logic       wr_en5 = 1'b0, clr_req5 = 1'b0;
  logic [2:0] wr_addr5 = '0, rd_addr_a5 = '0, rd_addr_b5 = '0;
  logic [7:0] wr_data5 = '0, rd_data_a5, rd_data_b5;
  logic       busy5, clr_done5, wr_err5;

  int n_checks = 0;
  int n_errors = 0;

  register_file #(.WIDTH(8), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
    .clr_req(clr_req), .busy(busy), .clr_done(clr_done), .wr_err(wr_err)
  );

  register_file #(.WIDTH(8), .DEPTH(5)) dut5 (
    .clk(clk), .rst(rst), .wr_en(wr_en5), .wr_addr(wr_addr5), .wr_data(wr_data5),
    .rd_addr_a(rd_addr_a5), .rd_data_a(rd_data_a5), .rd_addr_b(rd_addr_b5), .rd_data_b(rd_data_b5),
    .clr_req(clr_req5), .busy(busy5), .clr_done(clr_done5), .wr_err(wr_err5)
  );

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt;
    bit done_seen;

    // 1: reset, everything reads zero
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_val("reset_busy", {7'd0, busy}, 8'h00);
    check_val("reset_clr_done", {7'd0, clr_done}, 8'h00);
    check_val("reset_wr_err", {7'd0, wr_err}, 8'h00);
    for (int a = 0; a < 8; a++) begin
      rd_addr_a = 3'(a);
      rd_addr_b = 3'(7 - a);
      tick();
      check_val("reset_rd_a", rd_data_a, 8'h00);
      check_val("reset_rd_b", rd_data_b, 8'h00);
    end

    // 2: plain write then read on both ports
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'h5A;
    tick();
    wr_addr = 3'd7; wr_data = 8'hA5;
    tick();
    wr_en = 1'b0; rd_addr_a = 3'd3; rd_addr_b = 3'd7;
    tick();
    check_val("rd_a_addr3", rd_data_a, 8'h5A);
    check_val("rd_b_addr7", rd_data_b, 8'hA5);
    check_val("no_wr_err", {7'd0, wr_err}, 8'h00);

    // 3: write-first bypass; port B reads an unrelated entry
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h3C; rd_addr_a = 3'd2; rd_addr_b = 3'd3;
    tick();
    wr_en = 1'b0;
    check_val("bypass_a", rd_data_a, 8'h3C);
    check_val("bypass_b_other", rd_data_b, 8'h5A);
    rd_addr_b = 3'd2;
    tick();
    check_val("stored_a", rd_data_a, 8'h3C);
    check_val("same_addr_b", rd_data_b, 8'h3C);

    // 4: fill, then sweep clear
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = 8'(8'h11 * (i + 1));
      tick();
    end
    wr_en = 1'b0; rd_addr_a = 3'd5; rd_addr_b = 3'd0;
    tick();
    check_val("fill_rd5", rd_data_a, 8'h66);
    check_val("fill_rd0", rd_data_b, 8'h11);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      check_val("clr_busy", {7'd0, busy}, 8'h01);
      check_val("clr_done_pulse", {7'd0, clr_done}, {7'd0, k == 8});
      check_val("clr_wr_err", {7'd0, wr_err}, {7'd0, k == 4});
      wr_en   = (k == 3);
      wr_addr = 3'd1;
      wr_data = 8'hFF;
      clr_req = (k == 5);
      tick();
      wr_en   = 1'b0;
      clr_req = 1'b0;
    end
    check_val("clr_busy_end", {7'd0, busy}, 8'h00);
    check_val("clr_done_end", {7'd0, clr_done}, 8'h00);
    for (int a = 0; a < 8; a++) begin
      rd_addr_a = 3'(a);
      rd_addr_b = 3'(a);
      tick();
      check_val("cleared_a", rd_data_a, 8'h00);
      check_val("cleared_b", rd_data_b, 8'h00);
    end

    // 5: reset in the middle of a sweep
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = 8'h77;
      tick();
    end
    wr_en = 1'b0; rd_addr_a = 3'd6;
    tick();
    check_val("refill_rd6", rd_data_a, 8'h77);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    tick();
    tick();
    tick();
    check_val("mid_clr_busy", {7'd0, busy}, 8'h01);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("rst_mid_busy", {7'd0, busy}, 8'h00);
    check_val("rst_mid_done", {7'd0, clr_done}, 8'h00);
    for (int a = 0; a < 8; a++) begin
      rd_addr_a = 3'(a);
      rd_addr_b = 3'(7 - a);
      tick();
      check_val("rst_mid_rd_a", rd_data_a, 8'h00);
      check_val("rst_mid_rd_b", rd_data_b, 8'h00);
    end
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 8'h42; rd_addr_a = 3'd1;
    tick();
    wr_en = 1'b0; rd_addr_a = 3'd4;
    tick();
    check_val("post_rst_write", rd_data_a, 8'h42);

    // 6: DEPTH=5 out-of-range handling and 5-cycle sweep
    wr_en5 = 1'b1; wr_addr5 = 3'd4; wr_data5 = 8'h44;
    tick();
    check_val("d5_valid_wr_err", {7'd0, wr_err5}, 8'h00);
    wr_addr5 = 3'd6; wr_data5 = 8'h99;
    tick();
    check_val("d5_oob6_wr_err", {7'd0, wr_err5}, 8'h01);
    wr_addr5 = 3'd5; wr_data5 = 8'h55;
    tick();
    check_val("d5_oob5_wr_err", {7'd0, wr_err5}, 8'h01);
    wr_en5 = 1'b0; rd_addr_a5 = 3'd6; rd_addr_b5 = 3'd4;
    tick();
    check_val("d5_wr_err_clears", {7'd0, wr_err5}, 8'h00);
    check_val("d5_rd_oob6", rd_data_a5, 8'h00);
    check_val("d5_rd4", rd_data_b5, 8'h44);
    wr_en5 = 1'b1; wr_addr5 = 3'd7; wr_data5 = 8'hEE; rd_addr_a5 = 3'd7; rd_addr_b5 = 3'd5;
    tick();
    wr_en5 = 1'b0;
    check_val("d5_no_bypass_oob", rd_data_a5, 8'h00);
    check_val("d5_rd_oob5", rd_data_b5, 8'h00);
    for (int a = 0; a < 4; a++) begin
      rd_addr_a5 = 3'(a);
      tick();
      check_val("d5_unchanged", rd_data_a5, 8'h00);
    end
    clr_req5 = 1'b1;
    tick();
    clr_req5 = 1'b0;
    cnt = 0;
    done_seen = 1'b0;
    while (busy5 && cnt < 20) begin
      cnt++;
      if (clr_done5) done_seen = 1'b1;
      tick();
    end
    check_val("d5_sweep_len", 8'(cnt), 8'd5);
    check_val("d5_done_seen", {7'd0, done_seen}, 8'h01);
    rd_addr_a5 = 3'd4;
    tick();
    check_val("d5_cleared4", rd_data_a5, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
